// File: rtl/rob_multi_commit_pkg.sv
// Shared definitions for the reorder buffer: tag width derivation and the
// packed per-entry attribute layout.
package rob_multi_commit_pkg;

   function automatic int tag_bits(input int depth);
      return $clog2(depth);
   endfunction

   typedef struct packed {
      logic store;
      logic br;
      logic pred;
      logic taken;
   } rob_attr_t;

endpackage

// File: rtl/rob_commit_sel.sv
// Combinational in-order retire scan over the COMMIT_W oldest ROB slots.
module rob_commit_sel
   import rob_multi_commit_pkg::*;
#(
   parameter int COMMIT_W = 2,
   parameter int CNT_W    = $clog2(COMMIT_W + 1)
) (
   input  logic [COMMIT_W-1:0] busy,
   input  logic [COMMIT_W-1:0] done,
   input  rob_attr_t [COMMIT_W-1:0] attr,
   input  logic                st_ready,
   output logic [CNT_W-1:0]    retire_cnt,
   output logic [COMMIT_W-1:0] retire_mask,
   output logic [COMMIT_W-1:0] mis_mask
);

   logic go;

   always_comb begin
      go          = 1'b1;
      retire_cnt  = '0;
      retire_mask = '0;
      mis_mask    = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         if (go) begin
            if (!busy[k]) begin
               go = 1'b0;
            end else if (attr[k].store) begin
               // only the head store is visible to the SLB; it always ends the scan
               if (k == 0 && st_ready) begin
                  retire_mask[k] = 1'b1;
                  retire_cnt     = retire_cnt + 1'b1;
               end
               go = 1'b0;
            end else if (!done[k]) begin
               go = 1'b0;
            end else begin
               retire_mask[k] = 1'b1;
               retire_cnt     = retire_cnt + 1'b1;
               if (attr[k].br && (attr[k].taken != attr[k].pred)) begin
                  mis_mask[k] = 1'b1;
                  go          = 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order allocation, out-of-order writeback, up to COMMIT_W
// in-order retirements per cycle, store handshake and mispredict flush.
module rob_multi_commit
   import rob_multi_commit_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int TAG_W    = tag_bits(DEPTH),
   parameter int COMMIT_W = 2,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int REG_W    = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rdy,
   input  logic                         alloc_valid,
   output logic                         alloc_ready,
   output logic [TAG_W-1:0]             alloc_tag,
   input  logic [REG_W-1:0]             alloc_rd,
   input  logic                         alloc_store,
   input  logic                         alloc_br,
   input  logic                         alloc_pred,
   input  logic                         ex_valid,
   input  logic [TAG_W-1:0]             ex_tag,
   input  logic [DATA_W-1:0]            ex_data,
   input  logic                         ex_taken,
   input  logic [ADDR_W-1:0]            ex_target,
   input  logic                         slb_valid,
   input  logic [TAG_W-1:0]             slb_tag,
   input  logic [DATA_W-1:0]            slb_data,
   output logic                         st_valid,
   output logic [TAG_W-1:0]             st_tag,
   input  logic                         st_ready,
   output logic [COMMIT_W-1:0]          rf_we,
   output logic [COMMIT_W*REG_W-1:0]    rf_rd,
   output logic [COMMIT_W*DATA_W-1:0]   rf_data,
   output logic [COMMIT_W*TAG_W-1:0]    rf_tag,
   output logic                         flush,
   output logic [ADDR_W-1:0]            flush_pc,
   output logic [TAG_W:0]               count
);

   localparam int CNT_W = $clog2(COMMIT_W + 1);
   localparam logic [TAG_W:0] FULL = (TAG_W + 1)'(DEPTH);

   logic [TAG_W:0]      head, tail;
   logic [DEPTH-1:0]    busy, done;
   rob_attr_t           attr       [DEPTH];
   logic [REG_W-1:0]    rd_mem     [DEPTH];
   logic [DATA_W-1:0]   data_mem   [DEPTH];
   logic [ADDR_W-1:0]   target_mem [DEPTH];

   logic [COMMIT_W-1:0] rf_we_q;
   logic                flush_q;

   logic [TAG_W-1:0]    s_idx  [COMMIT_W];
   logic [REG_W-1:0]    s_rd   [COMMIT_W];
   logic [COMMIT_W-1:0] s_busy, s_done;
   rob_attr_t [COMMIT_W-1:0] s_attr;

   logic [CNT_W-1:0]    ret_cnt;
   logic [COMMIT_W-1:0] ret_mask, mis_mask;
   logic                mis;
   logic [ADDR_W-1:0]   mis_target;
   logic                alloc_fire, ex_hit, slb_hit;
   logic [TAG_W-1:0]    tail_idx;

   assign count       = tail - head;
   assign tail_idx    = tail[TAG_W-1:0];
   assign alloc_tag   = tail_idx;
   // flush_q holds ready low for the flush cycle so no entry lands in a dead window
   assign alloc_ready = rdy && !flush_q && (count != FULL);
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign ex_hit      = ex_valid && busy[ex_tag];
   assign slb_hit     = slb_valid && busy[slb_tag];
   assign st_tag      = head[TAG_W-1:0];
   assign st_valid    = busy[st_tag] && attr[st_tag].store;
   assign rf_we       = rf_we_q & {COMMIT_W{rdy}};
   assign flush       = flush_q && rdy;
   assign mis         = |mis_mask;

   always_comb begin
      mis_target = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         s_idx[k]  = head[TAG_W-1:0] + TAG_W'(k);
         s_busy[k] = busy[s_idx[k]];
         s_done[k] = done[s_idx[k]];
         s_attr[k] = attr[s_idx[k]];
         s_rd[k]   = rd_mem[s_idx[k]];
         if (mis_mask[k]) mis_target = target_mem[s_idx[k]];
      end
   end

   rob_commit_sel #(.COMMIT_W(COMMIT_W), .CNT_W(CNT_W)) u_sel (
      .busy        (s_busy),
      .done        (s_done),
      .attr        (s_attr),
      .st_ready    (st_ready),
      .retire_cnt  (ret_cnt),
      .retire_mask (ret_mask),
      .mis_mask    (mis_mask)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         head     <= '0;
         tail     <= '0;
         busy     <= '0;
         done     <= '0;
         rf_we_q  <= '0;
         rf_rd    <= '0;
         rf_data  <= '0;
         rf_tag   <= '0;
         flush_q  <= 1'b0;
         flush_pc <= '0;
      end else if (!rdy) begin
         // drop pulses so they do not reappear when rdy returns
         rf_we_q <= '0;
         flush_q <= 1'b0;
      end else begin
         flush_q <= mis;
         for (int k = 0; k < COMMIT_W; k++) begin
            rf_we_q[k]                   <= ret_mask[k] && !s_attr[k].store && (s_rd[k] != '0);
            rf_rd[k*REG_W +: REG_W]      <= s_rd[k];
            rf_data[k*DATA_W +: DATA_W]  <= data_mem[s_idx[k]];
            rf_tag[k*TAG_W +: TAG_W]     <= s_idx[k];
         end
         if (mis) begin
            head     <= '0;
            tail     <= '0;
            busy     <= '0;
            done     <= '0;
            flush_pc <= mis_target;
         end else begin
            if (ex_hit)  done[ex_tag]  <= 1'b1;
            if (slb_hit) done[slb_tag] <= 1'b1;
            for (int k = 0; k < COMMIT_W; k++) begin
               if (ret_mask[k]) begin
                  busy[s_idx[k]] <= 1'b0;
                  done[s_idx[k]] <= 1'b0;
               end
            end
            if (alloc_fire) begin
               busy[tail_idx] <= 1'b1;
               done[tail_idx] <= 1'b0;
               tail           <= tail + 1'b1;
            end
            head <= head + (TAG_W + 1)'(ret_cnt);
         end
      end
   end

   // payload storage needs no reset; busy gates every use of it
   always_ff @(posedge clk) begin
      if (!rst && rdy && !mis) begin
         if (ex_hit) begin
            data_mem[ex_tag]   <= ex_data;
            attr[ex_tag].taken <= ex_taken;
            target_mem[ex_tag] <= ex_target;
         end
         if (slb_hit) data_mem[slb_tag] <= slb_data;
         if (alloc_fire) begin
            rd_mem[tail_idx] <= alloc_rd;
            attr[tail_idx]   <= '{store: alloc_store, br: alloc_br, pred: alloc_pred, taken: 1'b0};
         end
      end
   end

endmodule
